rename_flow_ctrl: RTL and testbench
===================================

# rename_flow_ctrl

Admission and recovery controller in front of the 8-wide rename stage. Each cycle it decides whether the decoded 8-lane group may enter rename, based on ROB, RS and free-list credit and the checkpoint stack occupancy. It mirrors the rename checkpoint stack pointer. On a branch mispredict it sequences multi-cycle rollback, one checkpoint pop per cycle, followed by a fixed drain window.

## Interface
Parameters:
- CHECKPOINT_DEPTH, 16, rename checkpoint stack entries.
- DRAIN_CYCLES, 2, post-rollback cycles during which decode stays blocked (1..15).
- GROUP_W, 8, lanes per group and minimum credit needed from each resource.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- dec_valid_i  in  8  valid lane mask of the decoded group.
- dec_branch_i  in  8  lanes that require a checkpoint.
- dec_ready_o  out  1  group accepted this cycle.
- rob_free_i  in  9  free ROB entries.
- rs_free_i  in  7  free RS entries.
- free_list_count_i  in  7  free physical registers, from the rename free list.
- ren_valid_o  out  8  lane valids driven to rename.
- ren_checkpoint_o  out  8  checkpoint request lanes to rename.
- can_allocate_rob8_o  out  1  rob_free_i >= GROUP_W.
- can_allocate_rs8_o  out  1  rs_free_i >= GROUP_W.
- rollback_o  out  1  pop one rename checkpoint this cycle.
- mispredict_i  in  1  single-cycle mispredict pulse.
- mispredict_depth_i  in  5  checkpoints to discard (0 is treated as 1).
- cp_count_o  out  5  mirrored checkpoint stack pointer.
- busy_o  out  1  state != RUN.

## Operation
- FSM states: RUN, RECOVER, DRAIN. Registered state: rem_pop (5b), drain_cnt (4b), cp_count (5b).
- accept = state==RUN & !mispredict_i & |dec_valid_i & can_rob & can_rs & free_list_count_i>=GROUP_W & (!(|(dec_branch_i&dec_valid_i)) | cp_count<CHECKPOINT_DEPTH).
- dec_ready_o = accept. ren_valid_o = accept ? dec_valid_i : 0. ren_checkpoint_o = accept ? dec_branch_i&dec_valid_i : 0. All are combinational, with zero latency.
- Accepted group with any checkpoint lane: cp_count += 1. Only one push per group, matching rename.
- RUN + mispredict_i: d = max(depth,1), clamped to cp_count. If d>0, set rem_pop=d and go to RECOVER. If d=0, load drain_cnt=DRAIN_CYCLES and go to DRAIN.
- RECOVER: rollback_o=1 every cycle, cp_count-=1, rem_pop-=1. When rem_pop reaches 1, load drain_cnt and go to DRAIN on the next edge.
- RECOVER + mispredict_i: rem_pop += d. The sum is clamped to the cp_count remaining after this cycle's pop. A new mispredict never shortens an ongoing rollback.
- DRAIN: dec_ready_o=0 and drain_cnt decrements. Go to RUN once it reaches 0. A mispredict in DRAIN re-enters RECOVER using the RUN rules; if the clamp yields 0, drain_cnt is reloaded.
- rollback_o is never high in RUN. ren_valid_o is never nonzero outside RUN.
- cp_count saturates at 0 and at CHECKPOINT_DEPTH. Neither bound can be crossed by construction.

## Timing
- Reset values: state RUN, cp_count 0, rem_pop 0, drain_cnt 0.
- While rst_n=0, all outputs are 0. This includes dec_ready_o, rollback_o and busy_o.
- A reset assertion mid-RECOVER abandons the rollback immediately.
- Admission has 0-cycle latency: ready/valid are evaluated in the same cycle from the inputs.
- A mispredict seen at edge N produces the first rollback_o in cycle N+1. For depth d ≤ cp_count, rollback_o is high for exactly d cycles, followed by DRAIN_CYCLES blocked cycles.
- cp_count_o is registered. It updates one edge after the push or pop.

## Configuration
- RENAME_FLOW_PERF_EN defined: adds outputs perf_stall_rob_o, perf_stall_rs_o, perf_stall_fl_o, perf_stall_cp_o and perf_recover_o, each 32b and saturating.
  - Each stall counter increments in RUN when |dec_valid_i, accept=0 and its own condition fails. Several counters can increment in the same cycle.
  - perf_recover_o counts cycles in RECOVER or DRAIN.
  - All counters reset to 0.
- Undefined: these ports and their registers are absent. No other behaviour changes.

## Test plan
- Full credits (rob 64, rs 32, fl 96), dec_valid_i=8'hFF, no branches -> dec_ready_o=1, ren_valid_o=8'hFF, cp_count stays 0.
- free_list_count_i=7 with the other credits full -> dec_ready_o=0, ren_valid_o=0. Raising it to 8 -> accept in the same cycle.
- 16 accepted groups, each with dec_branch_i=8'h01, then a 17th branch group -> cp_count_o=16 and the 17th is stalled. A non-branch group is still accepted.
- cp_count=5, mispredict depth 3 -> rollback_o high for exactly 3 cycles, cp_count_o=2, busy_o high for 3+DRAIN_CYCLES cycles, then RUN.
- cp_count=2, mispredict depth 7 -> 2 rollback cycles (clamped), then DRAIN. A second mispredict during DRAIN with cp_count=0 -> no further rollback, drain_cnt reloads.
- Mispredict in the same cycle as a valid group with full credits -> dec_ready_o=0 and the group is not accepted. rst_n pulsed mid-RECOVER -> rollback_o=0 immediately, cp_count_o=0.

Source files
------------

// File: rtl/rename_flow_ctrl.sv
// rename_flow_ctrl: admission and mispredict-recovery controller in front of
// the 8-wide rename stage. It gates each decoded group on ROB/RS/free-list
// credit and checkpoint stack room, mirrors the rename checkpoint stack
// pointer, and sequences rollback (one pop per cycle) followed by a fixed
// drain window.
// Optional build macro: RENAME_FLOW_PERF_EN adds saturating 32-bit stall and
// recovery performance counters.
module rename_flow_ctrl #(
    parameter int CHECKPOINT_DEPTH = 16,
    parameter int DRAIN_CYCLES     = 2,
    parameter int GROUP_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dec_valid_i,
    input  logic [7:0] dec_branch_i,
    output logic       dec_ready_o,
    input  logic [8:0] rob_free_i,
    input  logic [6:0] rs_free_i,
    input  logic [6:0] free_list_count_i,
    output logic [7:0] ren_valid_o,
    output logic [7:0] ren_checkpoint_o,
    output logic       can_allocate_rob8_o,
    output logic       can_allocate_rs8_o,
    output logic       rollback_o,
    input  logic       mispredict_i,
    input  logic [4:0] mispredict_depth_i,
    output logic [4:0] cp_count_o,
    output logic       busy_o
`ifdef RENAME_FLOW_PERF_EN
    ,
    output logic [31:0] perf_stall_rob_o,
    output logic [31:0] perf_stall_rs_o,
    output logic [31:0] perf_stall_fl_o,
    output logic [31:0] perf_stall_cp_o,
    output logic [31:0] perf_recover_o
`endif
);

    localparam logic [4:0] CP_MAX    = 5'(CHECKPOINT_DEPTH);
    localparam logic [3:0] DRAIN_LD  = 4'(DRAIN_CYCLES);
    localparam logic [8:0] ROB_MIN   = 9'(GROUP_W);
    localparam logic [6:0] RS_MIN    = 7'(GROUP_W);
    localparam logic [6:0] FL_MIN    = 7'(GROUP_W);

    typedef enum logic [1:0] {RUN, RECOVER, DRAIN} state_t;

    state_t     state_q, state_d;
    logic [4:0] cp_count_q, cp_count_d;
    logic [4:0] rem_pop_q, rem_pop_d;
    logic [3:0] drain_cnt_q, drain_cnt_d;

    logic       has_cp, can_rob, can_rs, can_fl, cp_ok, accept;
    logic [4:0] depth_eff, d_new, cp_after, rem_after, rem_ext;
    logic [5:0] rem_sum;

    // Admission decision and depth arithmetic, all same-cycle from inputs.
    always_comb begin
        has_cp  = |(dec_branch_i & dec_valid_i);
        can_rob = rob_free_i >= ROB_MIN;
        can_rs  = rs_free_i >= RS_MIN;
        can_fl  = free_list_count_i >= FL_MIN;
        cp_ok   = !has_cp || (cp_count_q < CP_MAX);
        // rst_n is folded in so nothing is admitted while reset is held.
        accept  = rst_n && (state_q == RUN) && !mispredict_i && (|dec_valid_i)
                  && can_rob && can_rs && can_fl && cp_ok;

        // A zero depth still discards the youngest checkpoint.
        depth_eff = (mispredict_depth_i == 5'd0) ? 5'd1 : mispredict_depth_i;
        // Fresh rollback can never discard more checkpoints than exist.
        d_new     = (depth_eff > cp_count_q) ? cp_count_q : depth_eff;

        // Extension during rollback: clamp against what remains after this
        // cycle's pop. rem_after <= cp_after always, so this never shortens.
        cp_after  = (cp_count_q != 5'd0) ? cp_count_q - 5'd1 : 5'd0;
        rem_after = (rem_pop_q != 5'd0) ? rem_pop_q - 5'd1 : 5'd0;
        rem_sum   = {1'b0, rem_after} + {1'b0, depth_eff};
        rem_ext   = (rem_sum > {1'b0, cp_after}) ? cp_after : rem_sum[4:0];
    end

    // Next-state logic for the RUN/RECOVER/DRAIN sequencer and stack mirror.
    always_comb begin
        state_d     = state_q;
        cp_count_d  = cp_count_q;
        rem_pop_d   = rem_pop_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            RUN: begin
                if (mispredict_i) begin
                    if (d_new != 5'd0) begin
                        rem_pop_d = d_new;
                        state_d   = RECOVER;
                    end else begin
                        drain_cnt_d = DRAIN_LD;
                        state_d     = DRAIN;
                    end
                end else if (accept && has_cp && (cp_count_q < CP_MAX)) begin
                    // One push per group regardless of branch lane count.
                    cp_count_d = cp_count_q + 5'd1;
                end
            end
            RECOVER: begin
                cp_count_d = cp_after;
                if (mispredict_i) begin
                    if (rem_ext != 5'd0) begin
                        rem_pop_d = rem_ext;
                    end else begin
                        rem_pop_d   = 5'd0;
                        drain_cnt_d = DRAIN_LD;
                        state_d     = DRAIN;
                    end
                end else if (rem_pop_q <= 5'd1) begin
                    rem_pop_d   = 5'd0;
                    drain_cnt_d = DRAIN_LD;
                    state_d     = DRAIN;
                end else begin
                    rem_pop_d = rem_after;
                end
            end
            DRAIN: begin
                if (mispredict_i) begin
                    if (d_new != 5'd0) begin
                        rem_pop_d = d_new;
                        state_d   = RECOVER;
                    end else begin
                        // Nothing left to pop: restart the drain window.
                        drain_cnt_d = DRAIN_LD;
                    end
                end else if (drain_cnt_q <= 4'd1) begin
                    drain_cnt_d = 4'd0;
                    state_d     = RUN;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State registers; async reset abandons any rollback in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cp_count_q  <= 5'd0;
            rem_pop_q   <= 5'd0;
            drain_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            cp_count_q  <= cp_count_d;
            rem_pop_q   <= rem_pop_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Output drive; everything is forced low while reset is held.
    always_comb begin
        dec_ready_o         = accept;
        ren_valid_o         = accept ? dec_valid_i : 8'h00;
        ren_checkpoint_o    = accept ? (dec_branch_i & dec_valid_i) : 8'h00;
        can_allocate_rob8_o = rst_n && can_rob;
        can_allocate_rs8_o  = rst_n && can_rs;
        rollback_o          = rst_n && (state_q == RECOVER);
        busy_o              = rst_n && (state_q != RUN);
        cp_count_o          = cp_count_q;
    end

`ifdef RENAME_FLOW_PERF_EN
    logic [31:0] pc_rob_q, pc_rob_d, pc_rs_q, pc_rs_d, pc_fl_q, pc_fl_d;
    logic [31:0] pc_cp_q, pc_cp_d, pc_rec_q, pc_rec_d;
    logic        stall_run;

    // Saturating stall/recovery counters; several may step in one cycle.
    always_comb begin
        stall_run = (state_q == RUN) && (|dec_valid_i) && !accept;
        pc_rob_d  = pc_rob_q;
        pc_rs_d   = pc_rs_q;
        pc_fl_d   = pc_fl_q;
        pc_cp_d   = pc_cp_q;
        pc_rec_d  = pc_rec_q;
        if (stall_run && !can_rob && (pc_rob_q != '1)) pc_rob_d = pc_rob_q + 32'd1;
        if (stall_run && !can_rs  && (pc_rs_q  != '1)) pc_rs_d  = pc_rs_q + 32'd1;
        if (stall_run && !can_fl  && (pc_fl_q  != '1)) pc_fl_d  = pc_fl_q + 32'd1;
        if (stall_run && !cp_ok   && (pc_cp_q  != '1)) pc_cp_d  = pc_cp_q + 32'd1;
        if ((state_q != RUN) && (pc_rec_q != '1))      pc_rec_d = pc_rec_q + 32'd1;
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_rob_q <= 32'd0;
            pc_rs_q  <= 32'd0;
            pc_fl_q  <= 32'd0;
            pc_cp_q  <= 32'd0;
            pc_rec_q <= 32'd0;
        end else begin
            pc_rob_q <= pc_rob_d;
            pc_rs_q  <= pc_rs_d;
            pc_fl_q  <= pc_fl_d;
            pc_cp_q  <= pc_cp_d;
            pc_rec_q <= pc_rec_d;
        end
    end

    assign perf_stall_rob_o = pc_rob_q;
    assign perf_stall_rs_o  = pc_rs_q;
    assign perf_stall_fl_o  = pc_fl_q;
    assign perf_stall_cp_o  = pc_cp_q;
    assign perf_recover_o   = pc_rec_q;
`endif

endmodule

// File: tb/tb_rename_flow_ctrl.sv
// Directed bench for rename_flow_ctrl (default parameters, DRAIN_CYCLES=2).
module tb_rename_flow_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dec_valid_i, dec_branch_i;
    logic       dec_ready_o;
    logic [8:0] rob_free_i;
    logic [6:0] rs_free_i, free_list_count_i;
    logic [7:0] ren_valid_o, ren_checkpoint_o;
    logic       can_allocate_rob8_o, can_allocate_rs8_o, rollback_o;
    logic       mispredict_i;
    logic [4:0] mispredict_depth_i;
    logic [4:0] cp_count_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;
    int rb, bz, bad, done;

    rename_flow_ctrl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .dec_valid_i         (dec_valid_i),
        .dec_branch_i        (dec_branch_i),
        .dec_ready_o         (dec_ready_o),
        .rob_free_i          (rob_free_i),
        .rs_free_i           (rs_free_i),
        .free_list_count_i   (free_list_count_i),
        .ren_valid_o         (ren_valid_o),
        .ren_checkpoint_o    (ren_checkpoint_o),
        .can_allocate_rob8_o (can_allocate_rob8_o),
        .can_allocate_rs8_o  (can_allocate_rs8_o),
        .rollback_o          (rollback_o),
        .mispredict_i        (mispredict_i),
        .mispredict_depth_i  (mispredict_depth_i),
        .cp_count_o          (cp_count_o),
        .busy_o              (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Count rollback/busy cycles until busy drops, bounded.
    task automatic measure(output int n_rb, output int n_busy, output int n_bad, output int ok);
        n_rb = 0; n_busy = 0; n_bad = 0; ok = 0;
        for (int n = 0; n < 60; n++) begin
            if (!busy_o) begin
                ok = 1;
                break;
            end
            if (rollback_o) n_rb++;
            n_busy++;
            if (dec_ready_o || (ren_valid_o != 8'h00)) n_bad++;
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        dec_valid_i = 8'hFF; dec_branch_i = 8'h00;
        rob_free_i = 9'd64; rs_free_i = 7'd32; free_list_count_i = 7'd96;
        mispredict_i = 1'b0; mispredict_depth_i = 5'd0;
        #3;
        chk("rst_ready", 32'(dec_ready_o), 32'd0);
        chk("rst_ren_valid", 32'(ren_valid_o), 32'd0);
        chk("rst_can_rob", 32'(can_allocate_rob8_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rollback", 32'(rollback_o), 32'd0);
        chk("rst_cp", 32'(cp_count_o), 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // Full credits, no branches.
        #1;
        chk("full_ready", 32'(dec_ready_o), 32'd1);
        chk("full_ren_valid", 32'(ren_valid_o), 32'hFF);
        chk("full_ren_cp", 32'(ren_checkpoint_o), 32'h00);
        chk("full_can_rob", 32'(can_allocate_rob8_o), 32'd1);
        chk("full_can_rs", 32'(can_allocate_rs8_o), 32'd1);
        tick();
        chk("full_cp_stays0", 32'(cp_count_o), 32'd0);

        // Credit boundaries.
        free_list_count_i = 7'd7; #1;
        chk("fl7_ready", 32'(dec_ready_o), 32'd0);
        chk("fl7_ren_valid", 32'(ren_valid_o), 32'd0);
        free_list_count_i = 7'd8; #1;
        chk("fl8_ready", 32'(dec_ready_o), 32'd1);
        free_list_count_i = 7'd96; rob_free_i = 9'd7; #1;
        chk("rob7_can", 32'(can_allocate_rob8_o), 32'd0);
        chk("rob7_ready", 32'(dec_ready_o), 32'd0);
        rob_free_i = 9'd64; rs_free_i = 7'd7; #1;
        chk("rs7_can", 32'(can_allocate_rs8_o), 32'd0);
        chk("rs7_ready", 32'(dec_ready_o), 32'd0);
        rs_free_i = 7'd8; #1;
        chk("rs8_ready", 32'(dec_ready_o), 32'd1);
        rs_free_i = 7'd32; dec_valid_i = 8'h00; #1;
        chk("novalid_ready", 32'(dec_ready_o), 32'd0);
        tick();

        // Fill the checkpoint stack.
        dec_valid_i = 8'hFF; dec_branch_i = 8'h01;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("push_ready", 32'(dec_ready_o), 32'd1);
            if (i == 1) chk("push_cp1", 32'(cp_count_o), 32'd1);
            tick();
        end
        chk("full_stack_cp16", 32'(cp_count_o), 32'd16);
        #1;
        chk("cp17_ready", 32'(dec_ready_o), 32'd0);
        chk("cp17_ren_cp", 32'(ren_checkpoint_o), 32'd0);
        dec_valid_i = 8'h0E; #1;
        chk("branch_invalid_lane_ready", 32'(dec_ready_o), 32'd1);
        dec_valid_i = 8'hFF; dec_branch_i = 8'h00; #1;
        chk("nonbranch_ready", 32'(dec_ready_o), 32'd1);
        tick();
        chk("nonbranch_cp16", 32'(cp_count_o), 32'd16);

        // Mispredict alongside a valid group: group is refused.
        mispredict_i = 1'b1; mispredict_depth_i = 5'd11; #1;
        chk("mp_same_cycle_ready", 32'(dec_ready_o), 32'd0);
        chk("mp_same_cycle_ren", 32'(ren_valid_o), 32'd0);
        tick();
        mispredict_i = 1'b0;
        measure(rb, bz, bad, done);
        chk("d11_done", 32'(done), 32'd1);
        chk("d11_rollback", 32'(rb), 32'd11);
        chk("d11_busy", 32'(bz), 32'd13);
        chk("d11_no_admit", 32'(bad), 32'd0);
        chk("d11_cp", 32'(cp_count_o), 32'd5);

        // cp=5, depth 3.
        mispredict_i = 1'b1; mispredict_depth_i = 5'd3;
        tick();
        mispredict_i = 1'b0;
        measure(rb, bz, bad, done);
        chk("d3_done", 32'(done), 32'd1);
        chk("d3_rollback", 32'(rb), 32'd3);
        chk("d3_busy", 32'(bz), 32'd5);
        chk("d3_cp", 32'(cp_count_o), 32'd2);

        // cp=2, depth 7 clamps to 2; mispredict in DRAIN with empty stack.
        mispredict_i = 1'b1; mispredict_depth_i = 5'd7;
        tick();
        mispredict_i = 1'b0;
        chk("d7_rb_c1", 32'(rollback_o), 32'd1);
        tick();
        chk("d7_rb_c2", 32'(rollback_o), 32'd1);
        chk("d7_cp_c2", 32'(cp_count_o), 32'd1);
        tick();
        chk("d7_drain_rb", 32'(rollback_o), 32'd0);
        chk("d7_drain_busy", 32'(busy_o), 32'd1);
        chk("d7_cp0", 32'(cp_count_o), 32'd0);
        mispredict_i = 1'b1; mispredict_depth_i = 5'd3;
        tick();
        mispredict_i = 1'b0;
        measure(rb, bz, bad, done);
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_rb", 32'(rb), 32'd0);
        chk("reload_busy", 32'(bz), 32'd2);

        // Depth 0 is treated as 1.
        dec_branch_i = 8'h01;
        tick(); tick(); tick();
        dec_branch_i = 8'h00;
        chk("d0_cp3", 32'(cp_count_o), 32'd3);
        mispredict_i = 1'b1; mispredict_depth_i = 5'd0;
        tick();
        mispredict_i = 1'b0;
        measure(rb, bz, bad, done);
        chk("d0_rb", 32'(rb), 32'd1);
        chk("d0_busy", 32'(bz), 32'd3);
        chk("d0_cp", 32'(cp_count_o), 32'd2);

        // Mispredict during RECOVER extends the rollback (clamped).
        mispredict_i = 1'b1; mispredict_depth_i = 5'd1;
        tick();
        mispredict_depth_i = 5'd5;
        chk("ext_rb_c1", 32'(rollback_o), 32'd1);
        tick();
        mispredict_i = 1'b0;
        measure(rb, bz, bad, done);
        chk("ext_rb", 32'(rb), 32'd1);
        chk("ext_busy", 32'(bz), 32'd3);
        chk("ext_cp", 32'(cp_count_o), 32'd0);

        // Reset mid-RECOVER.
        dec_branch_i = 8'h01;
        tick(); tick(); tick(); tick();
        dec_branch_i = 8'h00;
        mispredict_i = 1'b1; mispredict_depth_i = 5'd4;
        tick();
        mispredict_i = 1'b0;
        tick();
        chk("midrec_rb", 32'(rollback_o), 32'd1);
        chk("midrec_cp", 32'(cp_count_o), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_rb", 32'(rollback_o), 32'd0);
        chk("midrst_cp", 32'(cp_count_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_ready", 32'(dec_ready_o), 32'd0);
        rst_n = 1'b1; #1;
        chk("postrst_ready", 32'(dec_ready_o), 32'd1);
        tick();
        chk("postrst_busy", 32'(busy_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
